sram_fill_checker: RTL

Bus-master pattern engine that drives the `sram_controller_if` controller-side signals (`wen`, `ram_wData`, `addr`, `byte_en`, `sram_en`) into an SRAM responder (`onchip_sram` or `memory_blocks`), honoring `sram_wait`. On `start` it fills a word-aligned address range with a generated pattern. It can optionally read the range back and compare each word, reporting a mismatch count and the first failing address. It sits beside the CPU port as the write-side counterpart of a read sweep, and serves for memory initialization, BIST and old/new memory equivalence runs.

---
 rtl/sram_fill_checker.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sram_fill_checker.sv
// Pattern fill / read-back compare engine driving the controller side of an SRAM port.
// Fills base + 4*i with a generated pattern, optionally re-reads and counts mismatches.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | bus quiescent, status held, waiting for start
// WRITE | write pass, one word per completed transfer
// READ  | read-back pass, compares ram_rData against the pattern
module sram_fill_checker #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 12
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      word_count,
  input  logic [1:0]            pattern_mode,
  input  logic [DATA_W-1:0]     seed,
  input  logic                  verify_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic                  sram_en,
  output logic                  wen,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     ram_wData,
  output logic [DATA_W/8-1:0]   byte_en,
  input  logic [DATA_W-1:0]     ram_rData,
  input  logic                  sram_wait
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  base_q, addr_q, first_err_q;
  logic [CNT_W-1:0]   cnt_q, idx_q;
  logic [1:0]         mode_q;
  logic [DATA_W-1:0]  seed_q, wdata_q;
  logic               verify_q, done_q, sram_en_q, wen_q;
  logic [15:0]        err_cnt_q;

  logic               xfer_d, last_d;
  logic [ADDR_W-1:0]  aligned_d, nxt_addr_d;
  logic [CNT_W-1:0]   nxt_idx_d;

  function automatic logic [DATA_W-1:0] pat_f(input logic [1:0] m, input logic [DATA_W-1:0] s,
                                              input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] i);
    case (m)
      2'd0:    pat_f = s;
      2'd1:    pat_f = DATA_W'(a);
      2'd2:    pat_f = s + DATA_W'(i);
      default: pat_f = ~DATA_W'(a);
    endcase
  endfunction

  assign xfer_d     = sram_en_q & ~sram_wait;
  assign last_d     = (idx_q == cnt_q - CNT_W'(1));
  assign aligned_d  = base_addr & ~ADDR_W'(3);
  assign nxt_addr_d = addr_q + ADDR_W'(4);
  assign nxt_idx_d  = idx_q + CNT_W'(1);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      first_err_q <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      mode_q      <= '0;
      seed_q      <= '0;
      wdata_q     <= '0;
      verify_q    <= 1'b0;
      done_q      <= 1'b0;
      sram_en_q   <= 1'b0;
      wen_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q      <= aligned_d;
            cnt_q       <= word_count;
            mode_q      <= pattern_mode;
            seed_q      <= seed;
            verify_q    <= verify_en;
            done_q      <= (word_count == '0);
            err_cnt_q   <= '0;
            first_err_q <= '0;
            idx_q       <= '0;
            if (word_count != '0) begin
              state_q   <= WRITE;
              sram_en_q <= 1'b1;
              wen_q     <= 1'b1;
              addr_q    <= aligned_d;
              wdata_q   <= pat_f(pattern_mode, seed, aligned_d, '0);
            end
          end
        end
        WRITE: begin
          if (xfer_d) begin
            if (!last_d) begin
              idx_q   <= nxt_idx_d;
              addr_q  <= nxt_addr_d;
              wdata_q <= pat_f(mode_q, seed_q, nxt_addr_d, nxt_idx_d);
            end else if (verify_q) begin
              state_q <= READ;
              idx_q   <= '0;
              wen_q   <= 1'b0;
              addr_q  <= base_q;
              wdata_q <= '0;
            end else begin
              state_q   <= IDLE;
              sram_en_q <= 1'b0;
              wen_q     <= 1'b0;
              addr_q    <= '0;
              wdata_q   <= '0;
              done_q    <= 1'b1;
            end
          end
        end
        READ: begin
          if (xfer_d) begin
            // first_err_addr latches only while no mismatch has been counted yet
            if (ram_rData != pat_f(mode_q, seed_q, addr_q, idx_q)) begin
              if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
              if (err_cnt_q == '0) first_err_q <= addr_q;
            end
            if (!last_d) begin
              idx_q  <= nxt_idx_d;
              addr_q <= nxt_addr_d;
            end else begin
              state_q   <= IDLE;
              sram_en_q <= 1'b0;
              addr_q    <= '0;
              done_q    <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign error          = (err_cnt_q != '0);
  assign err_count      = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign sram_en        = sram_en_q;
  assign wen            = wen_q;
  assign addr           = addr_q;
  assign ram_wData      = wdata_q;
  assign byte_en        = {(DATA_W/8){sram_en_q}};

endmodule
